// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and IF/ID record for the MIPS pipeline
package cpu_pkg;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          IMEM_ADDR_W = 9;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_plus4;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/if_id_register.sv
// rtl/if_id_register.sv - IF/ID pipeline register with flush > stall > fault > load priority
module if_id_register
    import cpu_pkg::*;
#(
    parameter logic [31:0] P_NOP_WORD = NOP_WORD
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_fault,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc_plus4,
    output if_id_t      o_if_id,
    output logic        o_load_valid
);

    if_id_t r_if_id;

    assign o_load_valid = !i_flush && !i_stall && !i_fault;
    assign o_if_id      = r_if_id;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_id.instruction <= P_NOP_WORD;
            r_if_id.pc_plus4    <= 32'h0;
            r_if_id.valid       <= 1'b0;
        end else if (i_flush) begin
            r_if_id.instruction <= P_NOP_WORD;
            r_if_id.pc_plus4    <= 32'h0;
            r_if_id.valid       <= 1'b0;
        end else if (i_stall) begin
            r_if_id <= r_if_id;
        end else if (i_fault) begin
            // pc_plus4 is left as-is; a bubble's link value is never consumed
            r_if_id.instruction <= P_NOP_WORD;
            r_if_id.valid       <= 1'b0;
        end else begin
            r_if_id.instruction <= i_instruction;
            r_if_id.pc_plus4    <= i_pc_plus4;
            r_if_id.valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC, next-PC selection, fault detect and fetch counter
module instruction_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC_P    = RESET_PC,
    parameter int          IMEM_ADDR_W_P = IMEM_ADDR_W,
    parameter logic [31:0] NOP_WORD_P    = NOP_WORD
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_stall,
    input  logic                     i_flush,
    input  logic                     i_redirect_valid,
    input  logic [31:0]              i_redirect_pc,
    output logic [IMEM_ADDR_W_P-1:0] o_imem_address,
    input  logic [31:0]              i_imem_instruction,
    output logic [31:0]              o_pc,
    output logic [31:0]              o_id_instruction,
    output logic [31:0]              o_id_pc_plus4,
    output logic                     o_id_valid,
    output logic                     o_fetch_fault,
    output logic [31:0]              o_fetch_count
);

    logic [31:0] r_pc;
    logic        r_fetch_fault;
    logic [31:0] r_fetch_count;

    logic [31:0] w_pc_plus4;
    logic        w_pc_fault;
    logic        w_redirect_misaligned;
    logic        w_squash;
    logic        w_load_valid;
    if_id_t      w_if_id;

    assign w_pc_plus4            = r_pc + 32'd4;
    assign w_pc_fault            = (r_pc[1:0] != 2'b00) || (|r_pc[31:IMEM_ADDR_W_P+2]);
    assign w_redirect_misaligned = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);
    assign w_squash              = i_flush || i_redirect_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC_P;
        end else if (i_redirect_valid) begin
            r_pc <= {i_redirect_pc[31:2], 2'b00};
        end else if (!i_stall) begin
            r_pc <= w_pc_plus4;
        end
    end

    // A misaligned redirect is reported as it lands, since its low bits are dropped
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_fault <= 1'b0;
        end else begin
            r_fetch_fault <= w_redirect_misaligned ||
                             (!w_squash && !i_stall && w_pc_fault);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fetch_count <= 32'h0;
        end else if (w_load_valid) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    if_id_register #(
        .P_NOP_WORD(NOP_WORD_P)
    ) u_if_id (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (w_squash),
        .i_stall      (i_stall),
        .i_fault      (w_pc_fault),
        .i_instruction(i_imem_instruction),
        .i_pc_plus4   (w_pc_plus4),
        .o_if_id      (w_if_id),
        .o_load_valid (w_load_valid)
    );

    assign o_imem_address   = r_pc[IMEM_ADDR_W_P+1:2];
    assign o_pc             = r_pc;
    assign o_id_instruction = w_if_id.instruction;
    assign o_id_pc_plus4    = w_if_id.pc_plus4;
    assign o_id_valid       = w_if_id.valid;
    assign o_fetch_fault    = r_fetch_fault;
    assign o_fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [8:0]  imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] pc;
    logic [31:0] id_instruction;
    logic [31:0] id_pc_plus4;
    logic        id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    instruction_fetch_stage dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_redirect_valid  (redirect_valid),
        .i_redirect_pc     (redirect_pc),
        .o_imem_address    (imem_address),
        .i_imem_instruction(imem_instruction),
        .o_pc              (pc),
        .o_id_instruction  (id_instruction),
        .o_id_pc_plus4     (id_pc_plus4),
        .o_id_valid        (id_valid),
        .o_fetch_fault     (fetch_fault),
        .o_fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [8:0] a);
        if (a == 9'd0) return 32'h2010_0000;
        return 32'hA500_0000 | {23'h0, a};
    endfunction

    assign imem_instruction = rom(imem_address);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
        step(); step();
        chk("reset_pc", pc, 32'h0);
        chk("reset_addr", {23'h0, imem_address}, 32'h0);
        chk("reset_valid", {31'h0, id_valid}, 32'h0);
        chk("reset_instr", id_instruction, 32'h0);
        chk("reset_fault", {31'h0, fetch_fault}, 32'h0);
        chk("reset_count", fetch_count, 32'h0);
        rst_n = 1'b1;
        step();
        chk("first_instr", id_instruction, 32'h2010_0000);
        chk("first_pc4", id_pc_plus4, 32'h4);
        chk("first_valid", {31'h0, id_valid}, 32'h1);
        chk("first_pc", pc, 32'h4);
        chk("first_count", fetch_count, 32'h1);
    endtask

    task automatic test_stall();
        repeat (4) step();
        chk("pre_stall_pc", pc, 32'h14);
        chk("pre_stall_count", fetch_count, 32'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, 32'h14);
            chk("stall_instr", id_instruction, rom(9'd4));
            chk("stall_pc4", id_pc_plus4, 32'h14);
            chk("stall_count", fetch_count, 32'd5);
        end
        stall = 1'b0;
        step();
        chk("resume_instr", id_instruction, rom(9'd5));
        chk("resume_pc4", id_pc_plus4, 32'h18);
        chk("resume_pc", pc, 32'h18);
        chk("resume_count", fetch_count, 32'd6);
    endtask

    task automatic test_redirect_flush();
        repeat (18) step();
        chk("at_0x60", pc, 32'h60);
        redirect_valid = 1; redirect_pc = 32'h108; flush = 1;
        step();
        redirect_valid = 0; flush = 0;
        chk("redir_pc", pc, 32'h108);
        chk("redir_addr", {23'h0, imem_address}, 32'h42);
        chk("redir_valid", {31'h0, id_valid}, 32'h0);
        chk("redir_instr", id_instruction, 32'h0);
        chk("redir_count", fetch_count, 32'd24);
        step();
        chk("target_instr", id_instruction, rom(9'h42));
        chk("target_valid", {31'h0, id_valid}, 32'h1);
        chk("target_pc4", id_pc_plus4, 32'h10C);
        chk("target_count", fetch_count, 32'd25);
    endtask

    task automatic test_stall_redirect();
        stall = 1; redirect_valid = 1; redirect_pc = 32'h98;
        step();
        stall = 0; redirect_valid = 0;
        chk("sr_pc", pc, 32'h98);
        chk("sr_valid", {31'h0, id_valid}, 32'h0);
        chk("sr_count", fetch_count, 32'd25);
        stall = 1; flush = 1;
        step();
        stall = 0; flush = 0;
        chk("sf_pc_hold", pc, 32'h98);
        chk("sf_valid", {31'h0, id_valid}, 32'h0);
        chk("sf_instr", id_instruction, 32'h0);
    endtask

    task automatic test_misaligned_redirect();
        redirect_valid = 1; redirect_pc = 32'h10A;
        step();
        redirect_valid = 0;
        chk("mis_pc", pc, 32'h108);
        chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
        chk("mis_valid", {31'h0, id_valid}, 32'h0);
        step();
        chk("mis_fault_clear", {31'h0, fetch_fault}, 32'h0);
        chk("mis_next_instr", id_instruction, rom(9'h42));
        chk("mis_next_valid", {31'h0, id_valid}, 32'h1);
    endtask

    task automatic test_range_boundary();
        int budget = 1000;
        while (pc !== 32'h7FC && budget > 0) begin
            step();
            budget--;
        end
        chk("reach_7fc", pc, 32'h7FC);
        step();
        chk("last_instr", id_instruction, rom(9'h1FF));
        chk("last_valid", {31'h0, id_valid}, 32'h1);
        chk("last_fault", {31'h0, fetch_fault}, 32'h0);
        chk("pc_800", pc, 32'h800);
        step();
        chk("oor_fault", {31'h0, fetch_fault}, 32'h1);
        chk("oor_instr", id_instruction, 32'h0);
        chk("oor_valid", {31'h0, id_valid}, 32'h0);
        chk("oor_pc", pc, 32'h804);
    endtask

    task automatic test_count_wrap();
        redirect_valid = 1; redirect_pc = 32'h0; flush = 1;
        step();
        redirect_valid = 0; flush = 0;
        force dut.r_fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_count;
        step();
        chk("wrap_valid", {31'h0, id_valid}, 32'h1);
        chk("wrap_count", fetch_count, 32'h0);
    endtask

    task automatic test_async_reset();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_pc", pc, 32'h0);
        chk("areset_valid", {31'h0, id_valid}, 32'h0);
        chk("areset_count", fetch_count, 32'h0);
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_flush();
        test_stall_redirect();
        test_misaligned_redirect();
        test_range_boundary();
        test_count_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
